// File: rtl/boot_image_loader_pkg.sv
// rtl/boot_image_loader_pkg.sv - shared types and constants for the boot image loader
// Purpose: copy-engine FSM state encoding and the stock BIOS ROM depth.
// Ports: none (package).
package boot_image_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int BIOS_DEPTH = 191;

endpackage

// File: rtl/boot_image_loader_if.sv
// rtl/boot_image_loader_if.sv - instruction-memory write port (ready/valid style)
// Purpose: groups the loader-to-instruction-memory write handshake.
// Signals: mem_wr_en (request), mem_wr_addr, mem_wr_data, mem_wr_ready (accept).
// Modports: master (loader side), slave (memory side).
interface boot_image_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;

  modport master (output mem_wr_en, output mem_wr_addr, output mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_en, input mem_wr_addr, input mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/boot_image_loader_rom.sv
// rtl/boot_image_loader_rom.sv - boot_rom: single-port registered-read boot image ROM
// Purpose: holds the boot image given as a packed parameter (word i at bits i*DATA_W).
// Ports: clock, reset_n (async active-low), en (read strobe), addr (read address),
//        data (registered read data; holds when en=0; 0 for addr >= DEPTH).
module boot_rom #(
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 12,
  parameter int                      DEPTH    = 191,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMG = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] img [DEPTH];
  logic              in_range;

  for (genvar i = 0; i < DEPTH; i++) begin : g_img
    assign img[i] = INIT_IMG[i*DATA_W +: DATA_W];
  end

  assign in_range = ({1'b0, addr} < DEPTH_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (en) begin
      data <= in_range ? img[addr[IW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/boot_image_loader.sv
// rtl/boot_image_loader.sv - boot image copy engine with direct fetch port and checksum
// Purpose: after reset or start-in-DONE, copies BOOT_LEN ROM words to instruction memory
//          at DST_BASE (wrapping mod 2^ADDR_W), holding the CPU until done; serves fetches in DONE.
// Ports: clock, reset_n (async active-low), start (re-boot pulse, DONE only),
//        fetch_en/fetch_addr -> fetch_data/fetch_valid (1-cycle latency),
//        mem (write port master), busy, done, cpu_hold, checksum (sum of words written this boot).
module boot_image_loader
  import boot_image_loader_pkg::*;
#(
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 12,
  parameter int                      DEPTH    = BIOS_DEPTH,
  parameter int                      BOOT_LEN = DEPTH,
  parameter int                      DST_BASE = 0,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMG = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       fetch_en,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic [DATA_W-1:0]          fetch_data,
  output logic                       fetch_valid,
  boot_image_loader_if.master        mem,
  output logic                       busy,
  output logic                       done,
  output logic                       cpu_hold,
  output logic [DATA_W-1:0]          checksum
);

  localparam logic [ADDR_W-1:0] DST  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BOOT_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] fetch_last;
  logic              fetch_accept;
  logic              rom_en;

  // Fetches are only honoured once the copy has finished.
  assign fetch_accept = fetch_en && (state == ST_DONE);
  // The ROM is strobed only for a copy read or an accepted fetch, so its output
  // stays put while a write is stalled on mem_wr_ready.
  assign rom_en       = (state == ST_READ) || fetch_accept;
  assign rom_addr     = busy ? idx : fetch_addr;

  // Write address/data are forced to 0 outside WRITE so reset values are all-zero.
  assign mem.mem_wr_addr = mem.mem_wr_en ? (DST + idx) : '0;
  assign mem.mem_wr_data = mem.mem_wr_en ? rom_q : '0;

  // Fresh ROM data in the valid cycle, otherwise the last fetched word.
  assign fetch_data = fetch_valid ? rom_q : fetch_last;

  boot_rom #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_IMG (INIT_IMG)
  ) u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (rom_en),
    .addr    (rom_addr),
    .data    (rom_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      checksum      <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.mem_wr_en <= 1'b0;
      fetch_valid   <= 1'b0;
      fetch_last    <= '0;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_valid) begin
        fetch_last <= rom_q;
      end
      case (state)
        ST_IDLE: begin
          idx      <= '0;
          checksum <= '0;
          busy     <= 1'b1;
          state    <= ST_READ;
        end
        ST_READ: begin
          mem.mem_wr_en <= 1'b1;
          state         <= ST_WRITE;
        end
        ST_WRITE: begin
          if (mem.mem_wr_ready) begin
            checksum      <= checksum + rom_q;
            mem.mem_wr_en <= 1'b0;
            if (idx == LAST) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            idx      <= '0;
            checksum <= '0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
// tb/tb_boot_image_loader.sv - self-checking bench for boot_image_loader
module tb_boot_image_loader;

  localparam logic [127:0] IMG = {32'd4, 32'd3, 32'd2, 32'd1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fetch_en = 1'b0;
  logic [11:0] fetch_addr = '0;
  logic        ready_a = 1'b1;

  always #5 clk = ~clk;

  boot_image_loader_if #(.ADDR_W(12), .DATA_W(32)) bus_a ();
  boot_image_loader_if #(.ADDR_W(12), .DATA_W(32)) bus_b ();

  assign bus_a.mem_wr_ready = ready_a;
  assign bus_b.mem_wr_ready = 1'b1;

  logic [31:0] fetch_data_a, csum_a, fetch_data_b, csum_b;
  logic        fv_a, busy_a, done_a, hold_a, fv_b, busy_b, done_b, hold_b;

  boot_image_loader #(
    .DATA_W(32), .ADDR_W(12), .DEPTH(4), .BOOT_LEN(4), .DST_BASE(0), .INIT_IMG(IMG)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .start(start), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data_a), .fetch_valid(fv_a), .mem(bus_a),
    .busy(busy_a), .done(done_a), .cpu_hold(hold_a), .checksum(csum_a)
  );

  boot_image_loader #(
    .DATA_W(32), .ADDR_W(12), .DEPTH(4), .BOOT_LEN(4), .DST_BASE(4094), .INIT_IMG(IMG)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .start(1'b0), .fetch_en(1'b0), .fetch_addr(12'd0),
    .fetch_data(fetch_data_b), .fetch_valid(fv_b), .mem(bus_b),
    .busy(busy_b), .done(done_b), .cpu_hold(hold_b), .checksum(csum_b)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: image words, word index, running sum, done and fetch expectations.
  logic [31:0] img [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  int          m_idx = 0;
  logic [31:0] m_sum = '0;
  int          hs = 0;
  int          stall = 0;
  bit          exp_done = 1'b0;
  bit          exp_fv = 1'b0;
  logic [31:0] exp_fd = '0;
  logic [31:0] last_fd = '0;
  logic [11:0] qb [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_idx = 0; m_sum = '0; hs = 0; exp_done = 1'b0; exp_fv = 1'b0; last_fd = '0;
      chk("rst_wr_en", {31'd0, bus_a.mem_wr_en}, 32'd0);
      chk("rst_hold", {31'd0, hold_a}, 32'd1);
    end else begin
      chk("fetch_valid", {31'd0, fv_a}, {31'd0, exp_fv});
      if (exp_fv) begin
        chk("fetch_data", fetch_data_a, exp_fd);
        last_fd = exp_fd;
      end else begin
        chk("fetch_hold", fetch_data_a, last_fd);
      end
      chk("checksum", csum_a, m_sum);
      chk("done", {31'd0, done_a}, {31'd0, exp_done});
      chk("cpu_hold", {31'd0, hold_a}, {31'd0, !exp_done});
      if (done_a) chk("busy_in_done", {31'd0, busy_a}, 32'd0);
      if (bus_a.mem_wr_en) begin
        chk("wr_in_range", (m_idx < 4) ? 32'd1 : 32'd0, 32'd1);
        if (m_idx < 4) begin
          chk("wr_addr", {20'd0, bus_a.mem_wr_addr}, m_idx % 4096);
          chk("wr_data", bus_a.mem_wr_data, img[m_idx]);
        end
      end
      exp_fv = fetch_en && exp_done;
      exp_fd = (fetch_addr < 12'd4) ? img[fetch_addr[1:0]] : 32'd0;
      if (bus_a.mem_wr_en && ready_a && m_idx < 4) begin
        m_sum = m_sum + img[m_idx];
        m_idx++;
        hs++;
        if (m_idx == 4) exp_done = 1'b1;
      end
      if (bus_a.mem_wr_en && !ready_a) stall++;
      if (exp_done && start) begin
        m_idx = 0; m_sum = '0; hs = 0; exp_done = 1'b0;
      end
      if (bus_b.mem_wr_en) qb.push_back(bus_b.mem_wr_addr);
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_a) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_word(input logic [11:0] a, input string name);
    int n = 0;
    while (!(bus_a.mem_wr_en && bus_a.mem_wr_addr == a) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {20'd0, bus_a.mem_wr_addr}, {20'd0, a});
  endtask

  task automatic do_fetch(input logic [11:0] a, input logic [31:0] exp);
    @(posedge clk); #1 fetch_en = 1'b1; fetch_addr = a;
    @(posedge clk); #1 fetch_en = 1'b0;
    chk("fetch_lit_valid", {31'd0, fv_a}, 32'd1);
    chk("fetch_lit_data", fetch_data_a, exp);
    @(posedge clk); #1;
    chk("fetch_lit_drop", {31'd0, fv_a}, 32'd0);
    chk("fetch_lit_hold", fetch_data_a, exp);
  endtask

  initial begin
    int n;
    // Reset values
    #23;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_csum", csum_a, 32'd0);
    chk("rst_fv", {31'd0, fv_a}, 32'd0);
    chk("rst_addr_b", {20'd0, bus_b.mem_wr_addr}, 32'd0);

    // Auto-boot after release: 4 words, done on the 9th edge (IDLE cycle + 2 per word)
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    while (!done_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", n, 32'd9);
    chk("t1_csum", csum_a, 32'd10);
    chk("t1_hold", {31'd0, hold_a}, 32'd0);
    chk("t1_hs", hs, 32'd4);

    // Wrapping destination on the second instance
    chk("wrap_count", qb.size(), 32'd4);
    if (qb.size() >= 4) begin
      chk("wrap_a0", {20'd0, qb[0]}, 32'd4094);
      chk("wrap_a1", {20'd0, qb[1]}, 32'd4095);
      chk("wrap_a2", {20'd0, qb[2]}, 32'd0);
      chk("wrap_a3", {20'd0, qb[3]}, 32'd1);
    end
    chk("wrap_csum", csum_b, 32'd10);

    // Direct fetches in DONE
    do_fetch(12'd2, 32'd3);
    do_fetch(12'd200, 32'd0);
    do_fetch(12'd0, 32'd1);

    // Restart, fetch during busy dropped, start during busy ignored
    pulse_start();
    chk("rs_done", {31'd0, done_a}, 32'd0);
    chk("rs_hold", {31'd0, hold_a}, 32'd1);
    chk("rs_busy", {31'd0, busy_a}, 32'd1);
    fetch_en = 1'b1; fetch_addr = 12'd1;
    @(posedge clk); #1 fetch_en = 1'b0;
    chk("busy_fetch_drop", {31'd0, fv_a}, 32'd0);
    pulse_start();
    wait_done("restart");
    chk("rs_hs", hs, 32'd4);
    chk("rs_csum", csum_a, 32'd10);

    // Back-pressure: ready low for 3 cycles on word 2
    stall = 0;
    pulse_start();
    wait_word(12'd1, "bp_find_w1");
    @(posedge clk); #1 ready_a = 1'b0;
    @(posedge clk); #1;
    chk("bp_en", {31'd0, bus_a.mem_wr_en}, 32'd1);
    chk("bp_addr", {20'd0, bus_a.mem_wr_addr}, 32'd2);
    chk("bp_data", bus_a.mem_wr_data, 32'd3);
    repeat (3) @(posedge clk);
    #1 ready_a = 1'b1;
    wait_done("bp");
    chk("bp_stall", stall, 32'd3);
    chk("bp_hs", hs, 32'd4);
    chk("bp_csum", csum_a, 32'd10);

    // Asynchronous reset mid-copy
    pulse_start();
    wait_word(12'd2, "ar_find_w2");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", {31'd0, bus_a.mem_wr_en}, 32'd0);
    chk("ar_addr", {20'd0, bus_a.mem_wr_addr}, 32'd0);
    chk("ar_hold", {31'd0, hold_a}, 32'd1);
    chk("ar_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_csum", csum_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (!bus_a.mem_wr_en && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_first_addr", {20'd0, bus_a.mem_wr_addr}, 32'd0);
    wait_done("ar");
    chk("ar_hs", hs, 32'd4);
    chk("ar_final_csum", csum_a, 32'd10);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
